// File: rtl/seg7_result_display.sv
// Captures a signed ALU result, saturates it to SAT_LIMIT and converts it to BCD with a
// sequential double-dabble engine. The four display digits are scanned from the board clock.
//
// state | meaning
// IDLE  | waiting for result_valid
// CONV  | one double-dabble step per clock, 10 steps in total
// LOAD  | copy BCD, sign and saturation into the display registers; restart if a result is pending
module seg7_result_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int SAT_LIMIT = 999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_result,
    input  logic        result_valid,
    output logic        busy,
    output logic        digit_select_sign,
    output logic        digit_select_hunth,
    output logic        digit_select_tenth,
    output logic        digit_select_unit,
    output logic [7:0]  segment_select
);

    localparam int          CW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [31:0] SAT_32 = SAT_LIMIT[31:0];
    localparam logic [9:0]  SAT_10 = SAT_LIMIT[9:0];
    localparam logic [3:0]  BLANK  = 4'hF;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t      state, state_nx;
    logic        start;
    logic [3:0]  iter;
    logic [9:0]  shift_reg;
    logic [11:0] bcd, bcd_adj;
    logic        conv_neg, conv_sat;
    logic        pend_flag;
    logic [31:0] pend_val;

    logic [31:0] src, src_abs;
    logic        cap_neg, cap_sat;
    logic [9:0]  cap_mag;

    logic [3:0]  dig_h, dig_t, dig_u;
    logic        disp_neg, disp_sat;

    logic [CW-1:0] scan_cnt;
    logic [1:0]    digit_idx;
    logic [7:0]    sign_seg, seg_nx;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // A strobe in LOAD wins over the older pending value.
    always_comb begin
        src     = (state == LOAD && !result_valid) ? pend_val : cpu_result;
        cap_neg = src[31];
        src_abs = src[31] ? (~src + 32'd1) : src;
        cap_sat = src_abs > SAT_32;
        cap_mag = cap_sat ? SAT_10 : src_abs[9:0];
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        case (state)
            IDLE: begin
                if (result_valid) begin
                    start    = 1'b1;
                    state_nx = CONV;
                end
            end
            CONV: begin
                if (iter == 4'd9) state_nx = LOAD;
            end
            LOAD: begin
                if (result_valid || pend_flag) begin
                    start    = 1'b1;
                    state_nx = CONV;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
        end
    end

    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < 3; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iter      <= '0;
            shift_reg <= '0;
            bcd       <= '0;
            conv_neg  <= 1'b0;
            conv_sat  <= 1'b0;
        end else if (start) begin
            iter      <= '0;
            shift_reg <= cap_mag;
            bcd       <= '0;
            conv_neg  <= cap_neg;
            conv_sat  <= cap_sat;
        end else if (state == CONV) begin
            iter      <= iter + 4'd1;
            bcd       <= {bcd_adj[10:0], shift_reg[9]};
            shift_reg <= {shift_reg[8:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_flag <= 1'b0;
            pend_val  <= '0;
        end else if (start) begin
            pend_flag <= 1'b0;
        end else if (result_valid) begin
            pend_flag <= 1'b1;
            pend_val  <= cpu_result;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dig_h    <= BLANK;
            dig_t    <= BLANK;
            dig_u    <= BLANK;
            disp_neg <= 1'b0;
            disp_sat <= 1'b0;
        end else if (state == LOAD) begin
            dig_h    <= (bcd[11:8] == 4'd0) ? BLANK : bcd[11:8];
            dig_t    <= (bcd[11:4] == 8'd0) ? BLANK : bcd[7:4];
            dig_u    <= bcd[3:0];
            disp_neg <= conv_neg && (bcd != 12'd0);
            disp_sat <= conv_sat;
        end
    end

    always_comb begin
        sign_seg    = disp_neg ? 8'hBF : 8'hFF;
        sign_seg[7] = ~disp_sat;
        case (digit_idx)
            2'd0:    seg_nx = sign_seg;
            2'd1:    seg_nx = seg_decode(dig_h);
            2'd2:    seg_nx = seg_decode(dig_t);
            default: seg_nx = seg_decode(dig_u);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt           <= '0;
            digit_idx          <= '0;
            digit_select_sign  <= 1'b0;
            digit_select_hunth <= 1'b0;
            digit_select_tenth <= 1'b0;
            digit_select_unit  <= 1'b0;
            segment_select     <= 8'hFF;
        end else begin
            if (scan_cnt == CW'(SCAN_DIV - 1)) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            digit_select_sign  <= (digit_idx == 2'd0);
            digit_select_hunth <= (digit_idx == 2'd1);
            digit_select_tenth <= (digit_idx == 2'd2);
            digit_select_unit  <= (digit_idx == 2'd3);
            segment_select     <= seg_nx;
        end
    end

endmodule

// File: tb/tb_seg7_result_display.sv
// Self-checking bench for seg7_result_display: fixed vectors, random values against an
// arithmetic display model, and hand-written pending/reset sequences.
module tb_seg7_result_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_result;
    logic        result_valid;
    logic        busy;
    logic        digit_select_sign, digit_select_hunth, digit_select_tenth, digit_select_unit;
    logic [7:0]  segment_select;
    logic [3:0]  sel;

    int checks = 0;
    int errors = 0;
    bit watch8 = 0;
    bit seen8  = 0;

    typedef struct {
        logic [31:0] value;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[11];

    seg7_result_display #(.SCAN_DIV(4), .SAT_LIMIT(999)) dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_result         (cpu_result),
        .result_valid       (result_valid),
        .busy               (busy),
        .digit_select_sign  (digit_select_sign),
        .digit_select_hunth (digit_select_hunth),
        .digit_select_tenth (digit_select_tenth),
        .digit_select_unit  (digit_select_unit),
        .segment_select     (segment_select)
    );

    always #5 clk = ~clk;
    assign sel = {digit_select_sign, digit_select_hunth, digit_select_tenth, digit_select_unit};

    always @(negedge clk) begin
        if (watch8 && sel == 4'b0001 && segment_select == 8'h80) seen8 = 1;
    end

    // Expected segments {sign, hundreds, tens, units} from plain decimal arithmetic.
    function automatic logic [31:0] model(input logic [31:0] v);
        logic [7:0] codes [10];
        longint s, m;
        bit neg, sat;
        int h, t, u;
        logic [7:0] sg, hs, ts, us;
        codes = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        s   = longint'($signed(v));
        neg = (s < 0);
        m   = neg ? -s : s;
        sat = (m > 999);
        if (sat) m = 999;
        h = int'(m / 100);
        t = int'((m / 10) % 10);
        u = int'(m % 10);
        sg = neg ? 8'hBF : 8'hFF;
        if (sat) sg[7] = 1'b0;
        hs = (h == 0) ? 8'hFF : codes[h];
        ts = (h == 0 && t == 0) ? 8'hFF : codes[t];
        us = codes[u];
        return {sg, hs, ts, us};
    endfunction

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic check_cycle(input logic [31:0] e, input string name);
        logic [7:0] want;
        checks++;
        case (sel)
            4'b1000: want = e[31:24];
            4'b0100: want = e[23:16];
            4'b0010: want = e[15:8];
            4'b0001: want = e[7:0];
            default: begin
                errors++;
                $display("FAIL %s: digit select %b, want exactly one high", name, sel);
                return;
            end
        endcase
        if (segment_select !== want) begin
            errors++;
            $display("FAIL %s: segments %h, want %h (select %b)", name, segment_select, want, sel);
        end
    endtask

    task automatic check_window(input logic [31:0] e, input string name);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check_cycle(e, name);
        end
    endtask

    // Leaves the bench at the negedge after the sampling edge, strobe already dropped.
    task automatic strobe(input logic [31:0] v);
        @(negedge clk);
        cpu_result   = v;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic wait_conv(input string name);
        int cycles = 0;
        check_eq({name, " busy after strobe"}, {31'd0, busy}, 32'd1);
        while (busy && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        check_eq({name, " busy cycles"}, cycles, 32'd11);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        vecs[0]  = '{32'd123,        32'hFFF9A4B0};
        vecs[1]  = '{32'hFFFFFFD3,   32'hBFFF9992};
        vecs[2]  = '{32'd5000,       32'h7F909090};
        vecs[3]  = '{32'h80000000,   32'h3F909090};
        vecs[4]  = '{32'd0,          32'hFFFFFFC0};
        vecs[5]  = '{32'd999,        32'hFF909090};
        vecs[6]  = '{32'd1000,       32'h7F909090};
        vecs[7]  = '{32'hFFFFFC18,   32'h3F909090};
        vecs[8]  = '{32'd100,        32'hFFF9C0C0};
        vecs[9]  = '{32'd10,         32'hFFFFF9C0};
        vecs[10] = '{32'hFFFFFFFF,   32'hBFFFFFF9};

        reset        = 1'b0;
        result_valid = 1'b0;
        cpu_result   = '0;
        repeat (3) @(negedge clk);
        check_eq("reset busy", {31'd0, busy}, 32'd0);
        check_eq("reset select", {28'd0, sel}, 32'd0);
        check_eq("reset segments", {24'd0, segment_select}, 32'hFF);
        reset = 1'b1;

        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check_eq("scan select", {28'd0, sel}, {28'd0, 4'b1000 >> (((k - 1) / 4) % 4)});
            check_eq("scan blank segments", {24'd0, segment_select}, 32'hFF);
        end

        for (int i = 0; i < 11; i++) begin
            strobe(vecs[i].value);
            wait_conv("vector");
            @(negedge clk);
            check_window(vecs[i].exp, "vector display");
        end

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) v = $urandom;
            else v = 32'($urandom_range(0, 2200)) - 32'd1100;
            strobe(v);
            wait_conv("random");
            @(negedge clk);
            check_window(model(v), "random display");
        end

        // 7, then 8 and 9 while busy: 7 shows, 8 is overwritten, 9 follows.
        watch8 = 1;
        strobe(32'd7);
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            result_valid = 1'b0;
            if (n == 2) begin cpu_result = 32'd8; result_valid = 1'b1; end
            if (n == 5) begin cpu_result = 32'd9; result_valid = 1'b1; end
            if (n >= 12 && n <= 22) check_cycle(model(32'd7), "pending first value");
            if (n == 21) check_eq("pending busy held", {31'd0, busy}, 32'd1);
            if (n == 22) check_eq("pending busy drop", {31'd0, busy}, 32'd0);
        end
        check_window(model(32'd9), "pending latest value");
        watch8 = 0;
        check_eq("overwritten value never shown", {31'd0, seen8}, 32'd0);

        // Strobe landing exactly in the LOAD cycle.
        strobe(32'd7);
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            result_valid = 1'b0;
            if (n == 10) begin cpu_result = 32'hFFFFFFD6; result_valid = 1'b1; end
            if (n == 11) check_eq("load strobe busy", {31'd0, busy}, 32'd1);
            if (n == 21) check_eq("load strobe busy held", {31'd0, busy}, 32'd1);
            if (n == 22) check_eq("load strobe busy drop", {31'd0, busy}, 32'd0);
        end
        check_window(model(32'hFFFFFFD6), "load strobe display");

        // Reset in the middle of a conversion.
        strobe(32'd500);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("midreset busy", {31'd0, busy}, 32'd0);
        check_eq("midreset select", {28'd0, sel}, 32'd0);
        check_eq("midreset segments", {24'd0, segment_select}, 32'hFF);
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            check_eq("post reset busy", {31'd0, busy}, 32'd0);
            check_cycle(32'hFFFFFFFF, "post reset blank");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
